apb_regbank_n: RTL and testbench

- Parametrised APB3/APB4 slave register bank; successor to the single-register APB slave with one hw_ctl/hw_sts bit.
- Provides NUM_REGS read/write control registers, a synchronised read-only status register and a write-1-to-clear event register.
- Supports configurable wait states, byte strobes and slave-error signalling; drives a level interrupt.
- Sits between the APB fabric and external hardware.

---
 rtl/apb_regbank_n.sv | 201 ++++++++++++++++++++
 tb/tb_apb_regbank_n.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regbank_n.sv
`default_nettype none
// ============================================================================
//  Module   : apb_regbank_n
//  Purpose  : APB3/APB4 slave register bank. It holds NUM_REGS read/write
//             control registers, a synchronised read-only STATUS register and
//             a write-1-to-clear EVENT register that latches rising edges of
//             STATUS. It supports programmable wait states, byte strobes and
//             slave-error responses, and drives a level interrupt.
//  Config   : define APB_REGBANK_STRB_EN to honour i_pstrb. When it is left
//             undefined, every write is full-word.
//  Ports    : pclk, presetn       clock, asynchronous active-low reset
//             i_paddr..i_pstrb    APB request (address, direction, data, strobes)
//             o_prdata, o_pready, o_pslverr  APB response
//             o_hw_ctl            flattened control regs, reg k at [k*DW +: DW]
//             i_hw_sts            asynchronous status from external hardware
//             o_irq               OR of the EVENT register (registered)
//  Map      : index = paddr / (DW/8); 0..NUM_REGS-1 CTL (RW),
//             NUM_REGS STATUS (RO), NUM_REGS+1 EVENT (W1C), others unmapped
//  Revision : 1.0  initial release
// ============================================================================
module apb_regbank_n #(
  parameter int              AW          = 12,
  parameter int              DW          = 32,
  parameter int              NUM_REGS    = 8,
  parameter int              WAIT_STATES = 0,
  parameter logic [DW-1:0]   CTL_RESET   = '0,
  localparam int             SW          = DW / 8
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic [AW-1:0]          i_paddr,
  input  logic                   i_pwrite,
  input  logic                   i_psel,
  input  logic                   i_penable,
  input  logic [DW-1:0]          i_pwdata,
  input  logic [SW-1:0]          i_pstrb,
  output logic [DW-1:0]          o_prdata,
  output logic                   o_pready,
  output logic                   o_pslverr,
  output logic [NUM_REGS*DW-1:0] o_hw_ctl,
  input  logic [DW-1:0]          i_hw_sts,
  output logic                   o_irq
);

  localparam int              ALSB    = $clog2(SW);
  localparam int              IW      = AW - ALSB;
  localparam logic [IW-1:0]   STS_IDX = IW'(NUM_REGS);
  localparam logic [IW-1:0]   EVT_IDX = IW'(NUM_REGS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              write_q, write_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]     strb_q, strb_d;
  logic [DW-1:0]     ctl_q [NUM_REGS];
  logic [DW-1:0]     ctl_d [NUM_REGS];
  logic [DW-1:0]     sync1_q, sync2_q, sync3_q;
  logic [DW-1:0]     evt_q, evt_d;
  logic              irq_q;

  // --------------------------------------------------------------------------
  // Decode of the captured request
  // --------------------------------------------------------------------------
  logic [IW-1:0]     idx;
  logic              misaligned, is_ctl, is_sts, is_evt, err;
  logic              xfer_done, commit;
  logic [SW-1:0]     strb_eff;
  logic [DW-1:0]     bmask, rdata, clr;

  assign idx        = addr_q[AW-1:ALSB];
  assign misaligned = |addr_q[ALSB-1:0];
  assign is_ctl     = (idx < IW'(NUM_REGS));
  assign is_sts     = (idx == STS_IDX);
  assign is_evt     = (idx == EVT_IDX);
  assign err        = misaligned | ~(is_ctl | is_sts | is_evt) | (write_q & is_sts);

  // pready needs psel still high, so an abort never signals completion.
  assign xfer_done  = (state_q == S_ACCESS) && (cnt_q == 4'd0) && i_psel;
  assign commit     = xfer_done && write_q && !err;

`ifdef APB_REGBANK_STRB_EN
  assign strb_eff = strb_q;
`else
  // Strobes are captured but ignored; every write is full-word.
  logic unused_strb;
  assign unused_strb = ^strb_q;
  assign strb_eff    = '1;
`endif

  for (genvar b = 0; b < SW; b++) begin : g_bmask
    assign bmask[b*8 +: 8] = {8{strb_eff[b]}};
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (is_ctl && (idx == IW'(k))) rdata = ctl_q[k];
    end
    if (is_sts) rdata = sync2_q;
    if (is_evt) rdata = evt_q;
  end

  assign o_pready  = xfer_done;
  assign o_pslverr = xfer_done && err;
  assign o_prdata  = (xfer_done && !err && !write_q) ? rdata : '0;
  assign o_irq     = irq_q;

  // --------------------------------------------------------------------------
  // Transfer FSM; the request is captured while in SETUP, when the bus is
  // already in its access phase with the address held stable.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    case (state_q)
      S_IDLE: begin
        if (i_psel && !i_penable) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = 4'(WAIT_STATES);
        addr_d  = i_paddr;
        write_d = i_pwrite;
        wdata_d = i_pwdata;
        strb_d  = i_pstrb;
      end
      S_ACCESS: begin
        if (!i_psel) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = i_penable ? S_IDLE : S_SETUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register updates
  // --------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      ctl_d[k] = ctl_q[k];
      if (commit && is_ctl && (idx == IW'(k)))
        ctl_d[k] = (ctl_q[k] & ~bmask) | (wdata_q & bmask);
    end
  end

  // A rising edge in the same cycle as a clear of that bit keeps it set.
  assign clr   = (commit && is_evt) ? (wdata_q & bmask) : '0;
  assign evt_d = (evt_q & ~clr) | (sync2_q & ~sync3_q);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      for (int k = 0; k < NUM_REGS; k++) ctl_q[k] <= CTL_RESET;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      evt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      for (int k = 0; k < NUM_REGS; k++) ctl_q[k] <= ctl_d[k];
      sync1_q <= i_hw_sts;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      evt_q   <= evt_d;
      irq_q   <= |evt_q;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_hw_ctl
    assign o_hw_ctl[k*DW +: DW] = ctl_q[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_regbank_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_regbank_n
//  Purpose  : Self-checking bench for apb_regbank_n (DW=32, 8 regs, 3 waits).
//             A transaction-level register model predicts every response,
//             and directed literal checks pin that model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_regbank_n;

  localparam int          NREG = 8;
  localparam int          WS   = 3;
  localparam logic [31:0] CRST = 32'hC0DE_0001;

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic [11:0]       paddr = '0;
  logic              pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0]       pwdata = '0;
  logic [3:0]        pstrb = '0;
  logic [31:0]       prdata;
  logic              pready, pslverr, irq;
  logic [NREG*32-1:0] hw_ctl;
  logic [31:0]       hw_sts = '0;

  apb_regbank_n #(
    .AW(12), .DW(32), .NUM_REGS(NREG), .WAIT_STATES(WS), .CTL_RESET(CRST)
  ) dut (
    .pclk(pclk), .presetn(presetn), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_psel(psel), .i_penable(penable), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr),
    .o_hw_ctl(hw_ctl), .i_hw_sts(hw_sts), .o_irq(irq)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- status driver ----------------
  bit          sts_rand = 1'b0;
  logic [31:0] sts_val  = '0;
  always @(posedge pclk) begin
    #1;
    if (sts_rand) begin
      if ($urandom_range(0, 5) == 0) hw_sts = $urandom;
    end else begin
      hw_sts = sts_val;
    end
  end

  // ---------------- behavioural model ----------------
  // Current transaction as announced by the bus master.
  logic [11:0] xa = '0;
  logic        xw = 1'b0;
  logic [31:0] xd = '0;
  logic [3:0]  xs = '0;
  int          exp_done = -1;   // cycle in which pready must be high

  logic [31:0] m_ctl [NREG];
  logic [31:0] m_evt = '0;
  logic        m_irq = 1'b0;
  logic [31:0] h1 = '0, h2 = '0, h3 = '0;  // hw_sts seen 1, 2, 3 cycles back
  int          ctl_age = 0;

  function automatic bit f_err(input logic [11:0] a, input logic w);
    int idx;
    idx = int'(a >> 2);
    if (a[1:0] != 2'b00) return 1'b1;
    if (idx > NREG + 1) return 1'b1;
    if (w && idx == NREG) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] f_mask(input logic [3:0] s);
`ifdef APB_REGBANK_STRB_EN
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
`else
    return 32'hFFFF_FFFF | {28'd0, s & 4'd0};
`endif
  endfunction

  function automatic logic [31:0] f_rd(input logic [11:0] a);
    int idx;
    idx = int'(a >> 2);
    if (idx < NREG) return m_ctl[idx];
    if (idx == NREG) return h2;           // STATUS lags the pin by two cycles
    return m_evt;
  endfunction

  bit          e_rdy, e_err;
  logic [31:0] clr, nv;
  int          widx;

  always @(negedge pclk) begin
    if (!presetn) begin
      chk("rst_pready", 64'(pready), 64'd0);
      chk("rst_pslverr", 64'(pslverr), 64'd0);
      chk("rst_prdata", 64'(prdata), 64'd0);
      chk("rst_irq", 64'(irq), 64'd0);
      for (int k = 0; k < NREG; k++) begin
        chk($sformatf("rst_hw_ctl%0d", k), 64'(hw_ctl[k*32 +: 32]), 64'(CRST));
        m_ctl[k] = CRST;
      end
      m_evt = '0; m_irq = 1'b0; h1 = '0; h2 = '0; h3 = '0; ctl_age = 0;
    end else begin
      e_rdy = (cyc == exp_done);
      chk("pready", 64'(pready), 64'(e_rdy));
      if (e_rdy) begin
        e_err = f_err(xa, xw);
        chk("pslverr", 64'(pslverr), 64'(e_err));
        if (!xw) chk("prdata", 64'(prdata), e_err ? 64'd0 : 64'(f_rd(xa)));
      end else begin
        e_err = 1'b0;
        chk("pslverr_idle", 64'(pslverr), 64'd0);
        chk("prdata_idle", 64'(prdata), 64'd0);
      end
      chk("irq", 64'(irq), 64'(m_irq));
      if (ctl_age >= 2)
        for (int k = 0; k < NREG; k++)
          chk($sformatf("hw_ctl%0d", k), 64'(hw_ctl[k*32 +: 32]), 64'(m_ctl[k]));
      // state after the coming edge
      clr = '0;
      ctl_age++;
      if (e_rdy && xw && !e_err) begin
        widx = int'(xa >> 2);
        if (widx < NREG) begin
          nv = (m_ctl[widx] & ~f_mask(xs)) | (xd & f_mask(xs));
          if (nv != m_ctl[widx]) ctl_age = 0;
          m_ctl[widx] = nv;
        end else if (widx == NREG + 1) begin
          clr = xd & f_mask(xs);
        end
      end
      m_irq = |m_evt;
      m_evt = (m_evt & ~clr) | (h2 & ~h3);
      h3 = h2; h2 = h1; h1 = hw_sts;
    end
  end

  // ---------------- bus master ----------------
  task automatic apb_xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input bit abort, input bit keep,
                          output logic [31:0] rd, output logic er, output int lat);
    bit got;
    rd = '0; er = 1'b0; lat = 0; got = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
    xa = a; xw = w; xd = d; xs = s;
    exp_done = abort ? -1 : cyc + 2 + WS;
    @(posedge pclk); #1;
    penable = 1'b1;
    if (abort) begin
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
    end else begin
      for (int i = 0; i < 64; i++) begin
        @(negedge pclk);
        if (pready) begin
          got = 1'b1; rd = prdata; er = pslverr;
          break;
        end
        lat++;
      end
      chk("pready_seen", 64'(got), 64'd1);
      if (!keep || !got) begin
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
      end
    end
  endtask

  task automatic rd_reg(input logic [11:0] a, output logic [31:0] rd, output logic er);
    int lat;
    apb_xfer(a, 1'b0, 32'd0, 4'hF, 1'b0, 1'b0, rd, er, lat);
  endtask

  task automatic wr_reg(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic er, output int lat);
    logic [31:0] rd;
    apb_xfer(a, 1'b1, d, s, 1'b0, 1'b0, rd, er, lat);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge pclk);
    #2 presetn = 1'b1;
    repeat (3) @(posedge pclk);

    // Reset contents
    for (int k = 0; k < NREG; k++) begin
      rd_reg(12'(k * 4), rd, er);
      chk("lit_reset_ctl", 64'(rd), 64'hC0DE_0001);
      chk("lit_reset_err", 64'(er), 64'd0);
    end
    rd_reg(12'h020, rd, er);
    chk("lit_status0", 64'(rd), 64'd0);

    // Wait states and write/readback
    wr_reg(12'h008, 32'hDEAD_BEEF, 4'hF, er, lat);
    chk("lit_wait_lat", 64'(lat), 64'd4);
    repeat (2) @(posedge pclk); #1;
    chk("lit_hw_ctl2", 64'(hw_ctl[95:64]), 64'hDEAD_BEEF);
    rd_reg(12'h008, rd, er);
    chk("lit_rb2", 64'(rd), 64'hDEAD_BEEF);

    // Byte strobes
    wr_reg(12'h004, 32'h1122_3344, 4'hF, er, lat);
    wr_reg(12'h004, 32'hAABB_CCDD, 4'b0101, er, lat);
    rd_reg(12'h004, rd, er);
`ifdef APB_REGBANK_STRB_EN
    chk("lit_strb", 64'(rd), 64'h11BB_33DD);
`else
    chk("lit_strb", 64'(rd), 64'hAABB_CCDD);
`endif

    // Error responses
    wr_reg(12'h100, 32'hFFFF_FFFF, 4'hF, er, lat);
    chk("lit_err_unmapped", 64'(er), 64'd1);
    wr_reg(12'h002, 32'hFFFF_FFFF, 4'hF, er, lat);
    chk("lit_err_misalign", 64'(er), 64'd1);
    wr_reg(12'h020, 32'hFFFF_FFFF, 4'hF, er, lat);
    chk("lit_err_status", 64'(er), 64'd1);
    rd_reg(12'h100, rd, er);
    chk("lit_err_rd", 64'(er), 64'd1);
    chk("lit_err_rdata", 64'(rd), 64'd0);
    rd_reg(12'h008, rd, er);
    chk("lit_err_nochg", 64'(rd), 64'hDEAD_BEEF);

    // Status, event, interrupt
    sts_val = 32'h1;
    repeat (8) @(posedge pclk);
    rd_reg(12'h020, rd, er);
    chk("lit_status1", 64'(rd), 64'h1);
    rd_reg(12'h024, rd, er);
    chk("lit_event1", 64'(rd), 64'h1);
    chk("lit_irq1", 64'(irq), 64'd1);
    wr_reg(12'h024, 32'h1, 4'hF, er, lat);
    repeat (3) @(posedge pclk); #1;
    chk("lit_irq0", 64'(irq), 64'd0);

    // Clear coinciding with a fresh rising edge
    sts_val = 32'h0; repeat (8) @(posedge pclk);
    sts_val = 32'h1; repeat (8) @(posedge pclk);
    sts_val = 32'h0; repeat (8) @(posedge pclk);
    fork
      wr_reg(12'h024, 32'h1, 4'hF, er, lat);
      begin
        repeat (4) @(posedge pclk);
        sts_val = 32'h1;
      end
    join
    repeat (3) @(posedge pclk);
    rd_reg(12'h024, rd, er);
    chk("lit_set_wins", 64'(rd[0]), 64'd1);
    wr_reg(12'h024, 32'hFFFF_FFFF, 4'hF, er, lat);

    // penable without a setup phase is ignored
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; paddr = 12'h000; pwrite = 1'b1; pwdata = 32'h0;
    repeat (4) @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;

    // Abort leaves the target untouched
    apb_xfer(12'h00C, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 1'b0, rd, er, lat);
    repeat (2) @(posedge pclk);
    rd_reg(12'h00C, rd, er);
    chk("lit_abort", 64'(rd), 64'hC0DE_0001);

    // Randomised traffic
    sts_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [11:0] a;
      int          sel;
      bit          ab, kp;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4, 5: a = 12'($urandom_range(0, NREG + 1) * 4);
        6:                a = 12'($urandom_range(NREG + 2, 1023) * 4);
        7:                a = 12'($urandom_range(0, NREG + 1) * 4 + $urandom_range(1, 3));
        8:                a = 12'h024;
        default:          a = 12'h020;
      endcase
      ab = ($urandom_range(0, 9) == 0);
      kp = ($urandom_range(0, 3) == 0);
      apb_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
               ab, kp, rd, er, lat);
      if (!kp) repeat ($urandom_range(0, 2)) @(posedge pclk);
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    sts_rand = 1'b0; sts_val = 32'h0;
    repeat (8) @(posedge pclk);

    // Reset during the ACCESS phase of a write
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h010; pwrite = 1'b1;
    pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
    exp_done = -1;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #3;
    presetn = 1'b0;
    #1;
    chk("lit_mid_rst_pready", 64'(pready), 64'd0);
    chk("lit_mid_rst_irq", 64'(irq), 64'd0);
    chk("lit_mid_rst_ctl4", 64'(hw_ctl[159:128]), 64'hC0DE_0001);
    repeat (2) @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    #1 presetn = 1'b1;
    repeat (3) @(posedge pclk);
    rd_reg(12'h010, rd, er);
    chk("lit_post_rst_ctl4", 64'(rd), 64'hC0DE_0001);
    rd_reg(12'h024, rd, er);
    chk("lit_post_rst_evt", 64'(rd), 64'd0);

    repeat (4) @(posedge pclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
